// File: rtl/music_sequencer.sv
// Beat sequencer: tempo prescaler plus beat counter with per-song run-time lengths,
// loop/one-shot modes, pause/resume and stop. Beat index feeds the tone lookup modules.
module music_sequencer #(
  parameter int BEAT_W   = 12,
  parameter int N_SONGS  = 4,
  parameter int SEL_W    = 2,
  parameter int TICK_DIV = 5000000,
  parameter int DIV_W    = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause_tog,
  input  logic                      loop_en,
  input  logic [SEL_W-1:0]          song_sel,
  input  logic [N_SONGS*BEAT_W-1:0] len_table,
  output logic [BEAT_W-1:0]         beat,
  output logic [SEL_W-1:0]          song_id,
  output logic                      beat_stb,
  output logic                      song_done,
  output logic                      playing,
  output logic                      paused
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   len_q, len_d;
  logic [SEL_W-1:0]    song_q, song_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;

  logic [BEAT_W-1:0]   sel_len;
  logic [BEAT_W:0]     beat_inc;
  logic                start_ok;
  logic                tick;
  logic                more_beats;

  // Length of the requested song; selects beyond N_SONGS read as empty.
  always_comb begin
    sel_len = '0;
    for (int k = 0; k < N_SONGS; k++) begin
      if (song_sel == SEL_W'(k)) begin
        sel_len = len_table[k*BEAT_W +: BEAT_W];
      end
    end
  end

  // One extra bit so a song of length 2^BEAT_W-1 still terminates correctly.
  assign beat_inc   = {1'b0, beat_q} + (BEAT_W+1)'(1);
  assign more_beats = beat_inc < {1'b0, len_q};
  assign start_ok   = start && (sel_len != '0);
  assign tick       = (state_q == S_PLAY) && (div_q == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      song_q  <= '0;
      div_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      song_q  <= song_d;
      div_q   <= div_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal gets a hold/default value first so no path through
  // the request decode can infer a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    song_d  = song_q;
    div_d   = div_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      beat_d  = '0;
      div_d   = '0;
    end else if (start_ok) begin
      state_d = S_PLAY;
      song_d  = song_sel;
      len_d   = sel_len;
      beat_d  = '0;
      div_d   = '0;
    end else if (pause_tog) begin
      // div_q and beat_q simply hold, which preserves the beat phase.
      case (state_q)
        S_PLAY:  state_d = S_PAUSE;
        S_PAUSE: state_d = S_PLAY;
        default: state_d = state_q;
      endcase
    end else if (state_q == S_PLAY) begin
      if (tick) begin
        div_d = '0;
        if (more_beats) begin
          beat_d = beat_inc[BEAT_W-1:0];
          stb_d  = 1'b1;
        end else if (loop_en) begin
          beat_d = '0;
          stb_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          beat_d  = '0;
          done_d  = 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    beat      = beat_q;
    song_id   = song_q;
    beat_stb  = stb_q;
    song_done = done_q;
    playing   = (state_q == S_PLAY);
    paused    = (state_q == S_PAUSE);
  end

endmodule
